// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch driver: command codes, FSM states and
// the width of the per-state cycle counter.
package sr_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_SET    = 2'b01,
      OP_RESET  = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PULSE = 2'b01,
      ST_GAP   = 2'b10,
      ST_CHECK = 2'b11
   } state_e;

endpackage

// File: rtl/sr_cycle_timer.sv
// Down-counter reloaded on each state entry; done marks the last cycle of the
// current state. The counter holds at zero instead of wrapping.
module sr_cycle_timer
   import sr_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             done
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a gated SR latch with timed set/reset pulses, tracks the expected
// latch state and flags any mismatch with the latch feedback.
module sr_latch_driver
   import sr_pkg::*;
#(
   parameter int PULSE_LEN = 2,
   parameter int GAP_LEN   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [1:0] req_op,
   output logic       req_ready,
   output logic       s,
   output logic       r,
   output logic       enable,
   input  logic       q,
   output logic       q_exp,
   output logic       err
);

   // The timer holds (length - 1) so that done is high in the final cycle.
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

   state_e           state_q, state_d;
   logic             target_q, target_d;
   logic             q_exp_q, q_exp_d;
   logic             err_q, err_d;
   logic             s_q, s_d;
   logic             r_q, r_d;
   logic             enable_q, enable_d;
   logic             ready_q, ready_d;
   logic             timer_load;
   logic [CNT_W-1:0] timer_value;
   logic             timer_done;
   logic             start;

   sr_cycle_timer u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (timer_load),
      .value (timer_value),
      .done  (timer_done)
   );

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      q_exp_d     = q_exp_q;
      err_d       = err_q;
      timer_load  = 1'b0;
      timer_value = '0;
      start       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               case (op_e'(req_op))
                  OP_SET: begin
                     target_d = 1'b1;
                     start    = 1'b1;
                  end
                  OP_RESET: begin
                     target_d = 1'b0;
                     start    = 1'b1;
                  end
                  OP_TOGGLE: begin
                     target_d = ~q_exp_q;
                     start    = 1'b1;
                  end
                  default: begin
                     start    = 1'b0;
                  end
               endcase
            end
            if (start) begin
               state_d     = ST_PULSE;
               timer_load  = 1'b1;
               timer_value = PULSE_LOAD;
            end
         end
         ST_PULSE: begin
            if (timer_done) begin
               state_d     = ST_GAP;
               q_exp_d     = target_q;
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (timer_done) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (q != q_exp_q) begin
               err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register with it;
      // s and r are mutually exclusive and gated by enable by construction.
      enable_d = (state_d == ST_PULSE);
      s_d      = enable_d & target_d;
      r_d      = enable_d & ~target_d;
      ready_d  = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         target_q <= 1'b0;
         q_exp_q  <= 1'b0;
         err_q    <= 1'b0;
         s_q      <= 1'b0;
         r_q      <= 1'b0;
         enable_q <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         q_exp_q  <= q_exp_d;
         err_q    <= err_d;
         s_q      <= s_d;
         r_q      <= r_d;
         enable_q <= enable_d;
         ready_q  <= ready_d;
      end
   end

   assign req_ready = ready_q;
   assign s         = s_q;
   assign r         = r_q;
   assign enable    = enable_q;
   assign q_exp     = q_exp_q;
   assign err       = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench: sr_latch_driver with default timing driving a gated SR
// latch model whose feedback can be forced stuck at 0.
module tb_sr_latch_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_op = 2'b00;
   logic       req_ready;
   logic       s;
   logic       r;
   logic       enable;
   logic       q;
   logic       q_exp;
   logic       err;

   logic       latch_q = 1'b0;
   logic       stuck0 = 1'b0;
   int         errors = 0;
   int         checks = 0;
   int         both_high = 0;
   int         ungated = 0;

   sr_latch_driver #(.PULSE_LEN(2), .GAP_LEN(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_ready (req_ready),
      .s         (s),
      .r         (r),
      .enable    (enable),
      .q         (q),
      .q_exp     (q_exp),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Gated NAND SR latch, modelled synchronously to clk.
   always @(posedge clk) begin
      if (enable && s && !r) latch_q <= 1'b1;
      else if (enable && r && !s) latch_q <= 1'b0;
   end
   assign q = stuck0 ? 1'b0 : latch_q;

   always @(posedge clk) begin
      assert (!(s && r)) else $error("[TB] s and r both high");
      if (s && r) both_high++;
      if ((s || r) && !enable) ungated++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [1:0] op);
      req_valid = 1'b1;
      req_op    = op;
      tick();
      req_valid = 1'b0;
      req_op    = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({s, r, enable} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_drives: s/r/enable=%b required 000", {s, r, enable});
      end
      checks++;
      if ({q_exp, err} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_state: q_exp/err=%b required 00", {q_exp, err});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_hold();
      accept(2'b00);
      tick();
      checks++;
      if ({req_ready, s, r, enable, q_exp} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL hold: ready/s/r/en/q_exp=%b required 10000", {req_ready, s, r, enable, q_exp});
      end
   endtask

   task automatic test_set();
      accept(2'b01);
      checks++;
      if ({s, r, enable, req_ready} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL set_c1: s/r/en/ready=%b required 1010", {s, r, enable, req_ready});
      end
      tick();
      checks++;
      if ({s, r, enable, req_ready} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL set_c2: s/r/en/ready=%b required 1010", {s, r, enable, req_ready});
      end
      tick();
      checks++;
      if ({s, r, enable, q_exp} !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL set_gap: s/r/en/q_exp=%b required 0001", {s, r, enable, q_exp});
      end
      tick();
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL set_check_ready: req_ready=%b required 0", req_ready);
      end
      tick();
      checks++;
      if ({req_ready, q, q_exp, err} !== 4'b1110) begin
         errors++;
         $display("[TB] FAIL set_done: ready/q/q_exp/err=%b required 1110", {req_ready, q, q_exp, err});
      end
   endtask

   task automatic test_reset_cmd();
      accept(2'b10);
      checks++;
      if ({s, r, enable} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL rst_c1: s/r/en=%b required 011", {s, r, enable});
      end
      tick();
      checks++;
      if ({s, r, enable} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL rst_c2: s/r/en=%b required 011", {s, r, enable});
      end
      tick();
      tick();
      tick();
      checks++;
      if ({req_ready, q, q_exp, err} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL rst_done: ready/q/q_exp/err=%b required 1000", {req_ready, q, q_exp, err});
      end
   endtask

   task automatic test_toggle();
      logic [2:0] seq;
      seq = 3'b000;
      for (int i = 0; i < 3; i++) begin
         accept(2'b11);
         for (int k = 0; k < 4; k++) tick();
         seq[2-i] = q;
         checks++;
         if (q_exp !== q) begin
            errors++;
            $display("[TB] FAIL toggle_qexp_%0d: q_exp=%b required %b", i, q_exp, q);
         end
      end
      checks++;
      if (seq !== 3'b101) begin
         errors++;
         $display("[TB] FAIL toggle_seq: q sequence=%b required 101", seq);
      end
      checks++;
      if (both_high !== 0 || ungated !== 0) begin
         errors++;
         $display("[TB] FAIL sr_exclusive: both_high=%0d ungated=%0d required 0 0", both_high, ungated);
      end
   endtask

   task automatic test_back_to_back();
      int accepts[$];
      logic prev_ready;
      prev_ready = 1'b0;
      req_valid = 1'b1;
      req_op    = 2'b01;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (prev_ready) begin
            checks++;
            if (s !== 1'b1) begin
               errors++;
               $display("[TB] FAIL b2b_accept_%0d: s=%b required 1", cyc, s);
            end
         end
         if (req_ready) accepts.push_back(cyc);
         prev_ready = req_ready;
         if (cyc == 15) begin
            req_valid = 1'b0;
            req_op    = 2'b00;
         end
         tick();
      end
      checks++;
      if (accepts.size() !== 4) begin
         errors++;
         $display("[TB] FAIL b2b_count: ready cycles=%0d required 4", accepts.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (accepts[i] - accepts[i-1] !== 5) begin
               errors++;
               $display("[TB] FAIL b2b_spacing_%0d: spacing=%0d required 5", i, accepts[i] - accepts[i-1]);
            end
         end
      end
   endtask

   task automatic test_stuck_err();
      stuck0 = 1'b1;
      accept(2'b01);
      tick();
      tick();
      tick();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_in_check: err=%b required 0", err);
      end
      tick();
      checks++;
      if ({err, q_exp, req_ready} !== 3'b111) begin
         errors++;
         $display("[TB] FAIL err_set: err/q_exp/ready=%b required 111", {err, q_exp, req_ready});
      end
      stuck0 = 1'b0;
      accept(2'b10);
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if ({err, q, q_exp} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL err_sticky: err/q/q_exp=%b required 100", {err, q, q_exp});
      end
   endtask

   task automatic test_reset_mid_pulse();
      accept(2'b01);
      tick();
      checks++;
      if ({s, enable} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL mid_pulse2: s/en=%b required 11", {s, enable});
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({s, r, enable, q_exp, req_ready, err} !== 6'b000010) begin
         errors++;
         $display("[TB] FAIL mid_reset: s/r/en/q_exp/ready/err=%b required 000010", {s, r, enable, q_exp, req_ready, err});
      end
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if ({s, r, enable, q_exp, req_ready, err} !== 6'b000010) begin
         errors++;
         $display("[TB] FAIL mid_abandon: s/r/en/q_exp/ready/err=%b required 000010", {s, r, enable, q_exp, req_ready, err});
      end
   endtask

   initial begin
      test_reset();
      test_hold();
      test_set();
      test_reset_cmd();
      test_toggle();
      test_back_to_back();
      test_stuck_err();
      test_reset_mid_pulse();
      checks++;
      if (both_high !== 0 || ungated !== 0) begin
         errors++;
         $display("[TB] FAIL sr_exclusive_final: both_high=%0d ungated=%0d required 0 0", both_high, ungated);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 2: cycles that s or r is held high per command; legal range 1..15.
REQ-002 SHALL have parameter GAP_LEN, default 1: cycles with s, r and enable all low after each pulse; legal range 1..15.
REQ-003 clk  input  1  single clock; every flop updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  1  command offered this cycle.
REQ-006 req_op  input  2  command code: 00 HOLD, 01 SET, 10 RESET, 11 TOGGLE.
REQ-007 req_ready  output  1  driver can accept a command this cycle.
REQ-008 s  output  1  set drive to the external latch.
REQ-009 r  output  1  reset drive to the external latch.
REQ-010 enable  output  1  gate enable to the external gated latch.
REQ-011 q  input  1  latch feedback; synchronous to clk.
REQ-012 q_exp  output  1  driver's model of the latch state.
REQ-013 err  output  1  sticky flag: latch feedback did not match q_exp.

Function
REQ-014 States SHALL be IDLE, PULSE, GAP and CHECK.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 A command is accepted on any edge where req_valid=1 and req_ready=1; no other command is accepted.
REQ-017 Accepted HOLD SHALL stay in IDLE, change no output, and leave req_ready=1.
REQ-018 Accepted SET, RESET or TOGGLE SHALL latch a target value and enter PULSE on the next cycle:
  - SET target = 1.
  - RESET target = 0.
  - TOGGLE target = ~q_exp, sampled at acceptance.
REQ-019 In PULSE, enable SHALL be 1 for exactly PULSE_LEN cycles, with s=target and r=~target.
REQ-020 After PULSE, the block SHALL enter GAP for exactly GAP_LEN cycles with s=r=enable=0.
REQ-021 q_exp SHALL update to the target on the PULSE-to-GAP transition.
REQ-022 CHECK SHALL last one cycle and compare q to q_exp:
  - on mismatch, err is set to 1;
  - the block then returns to IDLE in all cases.
REQ-023 s and r SHALL never both be 1 in any cycle, including the reset cycle.
REQ-024 s and r SHALL never be 1 while enable=0.
REQ-025 Command latency:
  - acceptance edge to first cycle of s or r high = 1 cycle;
  - acceptance to req_ready high again = PULSE_LEN+GAP_LEN+2 cycles.
REQ-026 req_valid and req_op SHALL be ignored outside IDLE; there is no queueing.
REQ-027 The cycle counter SHALL be 4 bits, loaded at each state entry, and SHALL never wrap.
REQ-028 err SHALL clear only on reset.

Reset
REQ-029 While rst_n=0 at a clock edge, the next state SHALL be:
  - state = IDLE;
  - s = r = enable = 0;
  - q_exp = 0, err = 0;
  - req_ready = 1 from the first cycle after reset deasserts.
REQ-030 Reset asserted mid-PULSE SHALL drop s, r and enable on the next edge and abandon the command with no CHECK.
REQ-031 The block SHALL never drive s=1 and r=1 on reset entry or exit.

Structure
REQ-032 Op codes, state encodings and the counter width SHALL live in shared package sr_pkg.
REQ-033 The cycle counter SHALL be one sub-module, sr_cycle_timer, with ports load, value and done.
REQ-034 The rest of the design SHALL be a single FSM with registered outputs.

Verification
REQ-035 The bench SHALL connect the driver to the gated NAND SR latch model and cover these scenarios:
  - Reset then SET, defaults: s high for 2 cycles starting 1 cycle after acceptance; enable high for those same 2 cycles; q=1; q_exp=1; err=0; req_ready back after 5 cycles.
  - RESET after SET: r high for 2 cycles; q=0; q_exp=0.
  - TOGGLE three times from q_exp=0: q sequence 1,0,1; s and r never both high.
  - req_valid held high with SET continuously: the next SET is accepted only when req_ready=1; commands are spaced exactly 5 cycles apart.
  - Force q stuck at 0 and issue SET: err=1 in the cycle after CHECK; err stays 1 through later good commands until rst_n=0.
  - rst_n=0 in the 2nd PULSE cycle: on the next edge s=r=enable=0, q_exp=0, req_ready=1.
REQ-036 An assertion SHALL fire on any cycle where !(s&r) does not hold.
